// File: rtl/axi_common_pkg.sv
// -----------------------------------------------------------------------------
// axi_common -- types and constants shared by the AXI-Lite blocks.
//   prot_t                    : AxPROT encoding
//   resp_t                    : xRESP encoding
//   AXI_LITE_ARB_MAX_MASTERS  : upper bound on arbiter fan-in
//   arb_idx_width()           : width of a grant index for n requesters
// -----------------------------------------------------------------------------
package axi_common;

  typedef logic [2:0] prot_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  localparam int AXI_LITE_ARB_MAX_MASTERS = 8;

  // A single requester still needs a 1-bit index so the vectors stay legal.
  function automatic int arb_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_channel.sv
// -----------------------------------------------------------------------------
// axi_lite_channel -- one AXI-Lite link (AW, W, B, AR, R).
//   Parameters: ADDR_WIDTH, DATA_WIDTH (32 or 64).
//   modport master : drives requests, receives responses.
//   modport slave  : receives requests, drives responses.
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both 1; valid, once raised, must stay up with a
// stable payload until that edge; ready may depend on valid combinationally.
// -----------------------------------------------------------------------------
interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64
);
  import axi_common::*;

  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  prot_t                   aw_prot;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;

  logic                    b_valid;
  logic                    b_ready;
  resp_t                   b_resp;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  prot_t                   ar_prot;

  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  resp_t                   r_resp;

  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

endinterface

// File: rtl/axi_lite_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_rr_arbiter -- combinational pick of one requester.
//   clk, rst : clock / synchronous active-high reset (pointer only)
//   req      : request vector, one bit per requester
//   advance  : 1 when the current pick is being taken as a grant
//   gnt_idx  : index of the picked requester (0 when nothing requests)
// Build option AXI_LITE_ARB_ROUND_ROBIN_EN: when defined the search starts at
// a pointer that moves to (grant + 1) mod N on every advance; otherwise the
// lowest requesting index wins and there is no pointer.
// -----------------------------------------------------------------------------
module axi_lite_rr_arbiter
  import axi_common::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = arb_idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [IDX_W-1:0] gnt_idx
);

`ifdef AXI_LITE_ARB_ROUND_ROBIN_EN

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               cand;

  // Rotate the search so that the pointer position has highest priority.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

`else

  // Walk from the top down so the lowest requesting index is left standing.
  always_comb begin
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) gnt_idx = IDX_W'(k);
    end
  end

  // Fixed priority keeps no history.
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, advance};

`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_arbiter -- NUM_MASTERS-to-1 AXI-Lite arbiter onto one slave link.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   masters : upstream links [NUM_MASTERS], index 0..NUM_MASTERS-1
//   slave   : downstream link
// Read and write paths are independent FSMs, one transaction in flight each:
//   write: W_IDLE -> W_FWD (AW and W each passed once) -> W_RESP (B) -> W_IDLE
//   read : R_IDLE -> R_FWD (AR) -> R_RESP (R) -> R_IDLE
// Grants are registered in IDLE, so the slave-side valid appears the cycle
// after a request. Ready/valid between the granted master and the slave are
// combinational pass-through. Non-granted masters see all readies/valids at 0.
// Build option AXI_LITE_ARB_ROUND_ROBIN_EN selects round-robin per direction
// (default: fixed priority, lowest index wins).
// Internal w_state / r_state carry the FSM states for observation.
// -----------------------------------------------------------------------------
module axi_lite_arbiter
  import axi_common::*;
#(
  parameter int NUM_MASTERS = 2,  // 2 .. AXI_LITE_ARB_MAX_MASTERS
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 64
) (
  input  logic           clk,
  input  logic           rst,
  axi_lite_channel.slave masters [NUM_MASTERS],
  axi_lite_channel.master slave
);

  localparam int IDX_W  = arb_idx_width(NUM_MASTERS);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP} r_state_t;

  // Upstream signals gathered into indexable vectors/arrays.
  logic [NUM_MASTERS-1:0] aw_req;
  logic [NUM_MASTERS-1:0] w_valid_v;
  logic [NUM_MASTERS-1:0] b_ready_v;
  logic [NUM_MASTERS-1:0] ar_req;
  logic [NUM_MASTERS-1:0] r_ready_v;
  logic [ADDR_WIDTH-1:0]  aw_addr_a [NUM_MASTERS];
  prot_t                  aw_prot_a [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  w_data_a  [NUM_MASTERS];
  logic [STRB_W-1:0]      w_strb_a  [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]  ar_addr_a [NUM_MASTERS];
  prot_t                  ar_prot_a [NUM_MASTERS];

  w_state_t         w_state, w_state_nxt;
  r_state_t         r_state, r_state_nxt;
  logic [IDX_W-1:0] wgnt, rgnt;
  logic [IDX_W-1:0] w_pick, r_pick;
  logic             aw_done, w_done;

  logic aw_fwd, w_fwd, b_route, ar_fwd, r_route;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic w_advance, r_advance;

  axi_lite_rr_arbiter #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_w_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (aw_req),
    .advance (w_advance),
    .gnt_idx (w_pick)
  );

  axi_lite_rr_arbiter #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_r_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (ar_req),
    .advance (r_advance),
    .gnt_idx (r_pick)
  );

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      wgnt    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (w_state == W_IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (|aw_req) wgnt <= w_pick;
      end else if (w_state == W_FWD) begin
        aw_done <= aw_done | aw_hs;
        w_done  <= w_done | w_hs;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      rgnt    <= '0;
    end else begin
      r_state <= r_state_nxt;
      if (r_state == R_IDLE && (|ar_req)) rgnt <= r_pick;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (|aw_req) w_state_nxt = W_FWD;
      // Leaving counts a handshake happening this very cycle as done.
      W_FWD:   if ((aw_done | aw_hs) && (w_done | w_hs)) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (|ar_req) r_state_nxt = R_FWD;
      R_FWD:   if (ar_hs) r_state_nxt = R_RESP;
      R_RESP:  if (r_hs) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    aw_fwd    = (w_state == W_FWD) && !aw_done;
    // The granted master may present W later than AW, so W valid follows it.
    w_fwd     = (w_state == W_FWD) && !w_done && w_valid_v[wgnt];
    b_route   = (w_state == W_RESP);
    ar_fwd    = (r_state == R_FWD);
    r_route   = (r_state == R_RESP);
    w_advance = (w_state == W_IDLE) && (|aw_req);
    r_advance = (r_state == R_IDLE) && (|ar_req);
    aw_hs     = aw_fwd && slave.aw_ready;
    w_hs      = w_fwd && slave.w_ready;
    b_hs      = b_route && slave.b_valid && b_ready_v[wgnt];
    ar_hs     = ar_fwd && slave.ar_ready;
    r_hs      = r_route && slave.r_valid && r_ready_v[rgnt];
  end

  // AW/AR valids come from registered state only: the granted master's
  // request is already known to be held high.
  assign slave.aw_valid = aw_fwd;
  assign slave.aw_addr  = aw_addr_a[wgnt];
  assign slave.aw_prot  = aw_prot_a[wgnt];
  assign slave.w_valid  = w_fwd;
  assign slave.w_data   = w_data_a[wgnt];
  assign slave.w_strb   = w_strb_a[wgnt];
  assign slave.b_ready  = b_route && b_ready_v[wgnt];
  assign slave.ar_valid = ar_fwd;
  assign slave.ar_addr  = ar_addr_a[rgnt];
  assign slave.ar_prot  = ar_prot_a[rgnt];
  assign slave.r_ready  = r_route && r_ready_v[rgnt];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_port
    localparam logic [IDX_W-1:0] IDX = IDX_W'(i);

    assign aw_req[i]    = masters[i].aw_valid;
    assign aw_addr_a[i] = masters[i].aw_addr;
    assign aw_prot_a[i] = masters[i].aw_prot;
    assign w_valid_v[i] = masters[i].w_valid;
    assign w_data_a[i]  = masters[i].w_data;
    assign w_strb_a[i]  = masters[i].w_strb;
    assign b_ready_v[i] = masters[i].b_ready;
    assign ar_req[i]    = masters[i].ar_valid;
    assign ar_addr_a[i] = masters[i].ar_addr;
    assign ar_prot_a[i] = masters[i].ar_prot;
    assign r_ready_v[i] = masters[i].r_ready;

    assign masters[i].aw_ready = aw_fwd && (wgnt == IDX) && slave.aw_ready;
    assign masters[i].w_ready  = w_fwd && (wgnt == IDX) && slave.w_ready;
    assign masters[i].b_valid  = b_route && (wgnt == IDX) && slave.b_valid;
    assign masters[i].ar_ready = ar_fwd && (rgnt == IDX) && slave.ar_ready;
    assign masters[i].r_valid  = r_route && (rgnt == IDX) && slave.r_valid;

    // Response payloads fan out to everyone; the per-master valid qualifies.
    assign masters[i].b_resp   = slave.b_resp;
    assign masters[i].r_data   = slave.r_data;
    assign masters[i].r_resp   = slave.r_resp;
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_arbiter -- directed bench for axi_lite_arbiter, NUM_MASTERS=3.
// Inputs change 1 ns after the rising edge; outputs are checked a further
// 1 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_axi_lite_arbiter;
  import axi_common::*;

  localparam int NM = 3;
  localparam int AW = 48;
  localparam int DW = 64;

  logic clk;
  logic rst;

  // Master-side drives and observations, mapped onto the interface array.
  logic [NM-1:0]     m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready;
  logic [AW-1:0]     m_aw_addr [NM];
  logic [AW-1:0]     m_ar_addr [NM];
  logic [DW-1:0]     m_w_data  [NM];
  logic [DW/8-1:0]   m_w_strb  [NM];
  logic [NM-1:0]     m_aw_ready, m_w_ready, m_b_valid, m_ar_ready, m_r_valid;
  logic [1:0]        m_b_resp  [NM];
  logic [1:0]        m_r_resp  [NM];
  logic [DW-1:0]     m_r_data  [NM];

  int checks;
  int errors;
  int rd_order [4];
  int g;
  logic [NM-1:0] one_hot;

  axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if [NM] ();
  axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

  for (genvar i = 0; i < NM; i++) begin : g_m
    assign m_if[i].aw_valid = m_aw_valid[i];
    assign m_if[i].aw_addr  = m_aw_addr[i];
    assign m_if[i].aw_prot  = 3'(i);
    assign m_if[i].w_valid  = m_w_valid[i];
    assign m_if[i].w_data   = m_w_data[i];
    assign m_if[i].w_strb   = m_w_strb[i];
    assign m_if[i].b_ready  = m_b_ready[i];
    assign m_if[i].ar_valid = m_ar_valid[i];
    assign m_if[i].ar_addr  = m_ar_addr[i];
    assign m_if[i].ar_prot  = 3'(i);
    assign m_if[i].r_ready  = m_r_ready[i];
    assign m_aw_ready[i]    = m_if[i].aw_ready;
    assign m_w_ready[i]     = m_if[i].w_ready;
    assign m_b_valid[i]     = m_if[i].b_valid;
    assign m_b_resp[i]      = m_if[i].b_resp;
    assign m_ar_ready[i]    = m_if[i].ar_ready;
    assign m_r_valid[i]     = m_if[i].r_valid;
    assign m_r_data[i]      = m_if[i].r_data;
    assign m_r_resp[i]      = m_if[i].r_resp;
  end

  axi_lite_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .masters (m_if),
    .slave   (s_if)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    s_if.aw_ready = 1'b0;
    s_if.w_ready  = 1'b0;
    s_if.ar_ready = 1'b0;
    s_if.b_valid  = 1'b0;
    s_if.b_resp   = RESP_OKAY;
    s_if.r_valid  = 1'b0;
    s_if.r_data   = '0;
    s_if.r_resp   = RESP_OKAY;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
`ifdef AXI_LITE_ARB_ROUND_ROBIN_EN
    rd_order = '{0, 1, 2, 0};
`else
    rd_order = '{0, 0, 0, 0};
`endif
    rst = 1'b1;
    m_aw_valid = '0; m_w_valid = '0; m_b_ready = '0; m_ar_valid = '0; m_r_ready = '0;
    for (int i = 0; i < NM; i++) begin
      m_aw_addr[i] = '0; m_ar_addr[i] = '0; m_w_data[i] = '0; m_w_strb[i] = '0;
    end
    slave_idle();

    // Reset: slave offers readies/valids, nothing may leak to any master.
    repeat (3) step();
    s_if.aw_ready = 1'b1; s_if.w_ready = 1'b1; s_if.ar_ready = 1'b1;
    s_if.b_valid = 1'b1; s_if.r_valid = 1'b1;
    #1;
    chk("rst_s_valids", {s_if.aw_valid, s_if.w_valid, s_if.ar_valid}, 0);
    chk("rst_s_readies", {s_if.b_ready, s_if.r_ready}, 0);
    chk("rst_m_readies", {m_aw_ready, m_w_ready, m_ar_ready}, 0);
    chk("rst_m_valids", {m_b_valid, m_r_valid}, 0);
    slave_idle();
    rst = 1'b0;
    step();

    // Single write from master 1, AW and W together.
    m_aw_valid[1] = 1'b1; m_aw_addr[1] = 48'h100;
    m_w_valid[1] = 1'b1; m_w_data[1] = 64'hDEAD; m_w_strb[1] = 8'hFF; m_b_ready[1] = 1'b1;
    #1;
    chk("t1_idle_aw_valid", s_if.aw_valid, 0);
    chk("t1_idle_w_valid", s_if.w_valid, 0);
    step();
    chk("t1_aw_valid", s_if.aw_valid, 1);
    chk("t1_aw_addr", s_if.aw_addr, 48'h100);
    chk("t1_w_valid", s_if.w_valid, 1);
    chk("t1_w_data", s_if.w_data, 64'hDEAD);
    chk("t1_w_strb", s_if.w_strb, 8'hFF);
    chk("t1_aw_ready_held", m_aw_ready, 0);
    s_if.aw_ready = 1'b1; s_if.w_ready = 1'b1;
    #1;
    chk("t1_m_aw_ready", m_aw_ready, 3'b010);
    chk("t1_m_w_ready", m_w_ready, 3'b010);
    step();
    m_aw_valid[1] = 1'b0; m_w_valid[1] = 1'b0;
    slave_idle();
    s_if.b_valid = 1'b1; s_if.b_resp = RESP_OKAY;
    #1;
    chk("t1_resp_aw_off", s_if.aw_valid, 0);
    chk("t1_resp_w_off", s_if.w_valid, 0);
    chk("t1_m_b_valid", m_b_valid, 3'b010);
    chk("t1_m_b_resp", m_b_resp[1], RESP_OKAY);
    chk("t1_s_b_ready", s_if.b_ready, 1);
    step();
    chk("t1_after_b_valid", m_b_valid, 0);
    chk("t1_after_b_ready", s_if.b_ready, 0);
    slave_idle();
    m_b_ready[1] = 1'b0;

    // W before AW on master 0; slave aw_ready late.
    m_w_valid[0] = 1'b1; m_w_data[0] = 64'hBEEF; m_w_strb[0] = 8'h0F; m_b_ready[0] = 1'b1;
    s_if.w_ready = 1'b1;
    #1;
    chk("t2_w_alone_valid", s_if.w_valid, 0);
    chk("t2_w_alone_ready", m_w_ready, 0);
    step(); step(); step();
    m_aw_valid[0] = 1'b1; m_aw_addr[0] = 48'h200;
    #1;
    chk("t2_idle_aw_valid", s_if.aw_valid, 0);
    step();
    chk("t2_fwd_aw_valid", s_if.aw_valid, 1);
    chk("t2_fwd_aw_addr", s_if.aw_addr, 48'h200);
    chk("t2_fwd_w_valid", s_if.w_valid, 1);
    chk("t2_fwd_w_data", s_if.w_data, 64'hBEEF);
    chk("t2_m_w_ready", m_w_ready, 3'b001);
    chk("t2_m_aw_ready_low", m_aw_ready, 0);
    step();
    // Master already presents another W beat; it must not be forwarded.
    m_w_data[0] = 64'h5A5A; s_if.w_ready = 1'b1; s_if.aw_ready = 1'b1;
    #1;
    chk("t2_w_not_reasserted", s_if.w_valid, 0);
    chk("t2_w_ready_after", m_w_ready, 0);
    chk("t2_aw_still_valid", s_if.aw_valid, 1);
    chk("t2_m_aw_ready", m_aw_ready, 3'b001);
    chk("t2_no_resp_yet", s_if.b_ready, 0);
    step();
    m_aw_valid[0] = 1'b0;
    slave_idle();
    #1;
    chk("t2_resp_b_ready", s_if.b_ready, 1);
    chk("t2_resp_aw_off", s_if.aw_valid, 0);
    chk("t2_resp_w_off", s_if.w_valid, 0);
    s_if.b_valid = 1'b1;
    #1;
    chk("t2_m_b_valid", m_b_valid, 3'b001);
    step();
    slave_idle();
    m_b_ready[0] = 1'b0; m_w_valid[0] = 1'b0;

    // Read contention, all three masters requesting continuously.
    for (int i = 0; i < NM; i++) begin
      m_ar_valid[i] = 1'b1; m_ar_addr[i] = 48'h1000 + 48'(i); m_r_ready[i] = 1'b1;
    end
    s_if.ar_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      g = rd_order[t];
      one_hot = '0;
      one_hot[g] = 1'b1;
      step();
      chk("t3_ar_valid", s_if.ar_valid, 1);
      chk("t3_ar_addr", s_if.ar_addr, 48'h1000 + 48'(g));
      chk("t3_m_ar_ready", m_ar_ready, one_hot);
      step();
      s_if.r_valid = 1'b1; s_if.r_data = 64'hA000 + 64'(t); s_if.r_resp = RESP_OKAY;
      #1;
      chk("t3_ar_off", s_if.ar_valid, 0);
      chk("t3_m_r_valid", m_r_valid, one_hot);
      chk("t3_m_r_data", m_r_data[g], 64'hA000 + 64'(t));
      step();
      s_if.r_valid = 1'b0;
      if (t == 3) m_ar_valid = '0;
    end
    slave_idle();
    m_r_ready = '0;

    // Concurrent write (master 0) and read (master 1).
    m_aw_valid[0] = 1'b1; m_aw_addr[0] = 48'h300;
    m_w_valid[0] = 1'b1; m_w_data[0] = 64'h1234; m_w_strb[0] = 8'hFF; m_b_ready[0] = 1'b1;
    m_ar_valid[1] = 1'b1; m_ar_addr[1] = 48'h400; m_r_ready[1] = 1'b1;
    #1;
    chk("t4_idle_valids", {s_if.aw_valid, s_if.ar_valid}, 0);
    step();
    chk("t4_fwd_valids", {s_if.aw_valid, s_if.ar_valid}, 2'b11);
    chk("t4_aw_addr", s_if.aw_addr, 48'h300);
    chk("t4_ar_addr", s_if.ar_addr, 48'h400);
    s_if.aw_ready = 1'b1; s_if.w_ready = 1'b1; s_if.ar_ready = 1'b1;
    #1;
    chk("t4_m_aw_ready", m_aw_ready, 3'b001);
    chk("t4_m_ar_ready", m_ar_ready, 3'b010);
    step();
    m_aw_valid[0] = 1'b0; m_w_valid[0] = 1'b0; m_ar_valid[1] = 1'b0;
    slave_idle();
    s_if.b_valid = 1'b1; s_if.b_resp = RESP_OKAY;
    s_if.r_valid = 1'b1; s_if.r_data = 64'h5555; s_if.r_resp = RESP_EXOKAY;
    #1;
    chk("t4_m_b_valid", m_b_valid, 3'b001);
    chk("t4_m_r_valid", m_r_valid, 3'b010);
    chk("t4_m_r_data", m_r_data[1], 64'h5555);
    chk("t4_m_r_resp", m_r_resp[1], RESP_EXOKAY);
    chk("t4_s_readies", {s_if.b_ready, s_if.r_ready}, 2'b11);
    step();
    slave_idle();
    m_b_ready = '0; m_r_ready = '0;

    // SLVERR to master 2 while it stalls b_ready for 4 cycles.
    m_aw_valid[2] = 1'b1; m_aw_addr[2] = 48'h500;
    m_w_valid[2] = 1'b1; m_w_data[2] = 64'hCAFE; m_w_strb[2] = 8'hFF; m_b_ready[2] = 1'b0;
    s_if.aw_ready = 1'b1; s_if.w_ready = 1'b1;
    step();
    chk("t5_m_aw_ready", m_aw_ready, 3'b100);
    chk("t5_m_w_ready", m_w_ready, 3'b100);
    step();
    m_aw_valid[2] = 1'b0; m_w_valid[2] = 1'b0;
    slave_idle();
    s_if.b_valid = 1'b1; s_if.b_resp = RESP_SLVERR;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t5_b_valid_stable", m_b_valid, 3'b100);
      chk("t5_b_resp", m_b_resp[2], RESP_SLVERR);
      chk("t5_s_b_ready_low", s_if.b_ready, 0);
      step();
    end
    m_b_ready[2] = 1'b1;
    #1;
    chk("t5_s_b_ready", s_if.b_ready, 1);
    chk("t5_b_valid_accept", m_b_valid, 3'b100);
    step();
    chk("t5_idle_b_valid", m_b_valid, 0);
    chk("t5_idle_b_ready", s_if.b_ready, 0);
    slave_idle();
    m_b_ready[2] = 1'b0;

    // Reset in W_FWD with AW pending, then the same request again.
    m_aw_valid[1] = 1'b1; m_aw_addr[1] = 48'h600; m_w_valid[1] = 1'b0;
    step();
    chk("t6_fwd_aw_valid", s_if.aw_valid, 1);
    rst = 1'b1;
    step();
    s_if.aw_ready = 1'b1; s_if.w_ready = 1'b1; s_if.ar_ready = 1'b1;
    #1;
    chk("t6_rst_s_valids", {s_if.aw_valid, s_if.w_valid, s_if.ar_valid}, 0);
    chk("t6_rst_m_readies", {m_aw_ready, m_w_ready, m_ar_ready}, 0);
    chk("t6_rst_m_valids", {m_b_valid, m_r_valid}, 0);
    rst = 1'b0;
    slave_idle();
    step();
    m_w_valid[1] = 1'b1; m_w_data[1] = 64'h77; m_w_strb[1] = 8'hFF; m_b_ready[1] = 1'b1;
    #1;
    chk("t6_regrant_aw_valid", s_if.aw_valid, 1);
    chk("t6_regrant_aw_addr", s_if.aw_addr, 48'h600);
    chk("t6_regrant_w_valid", s_if.w_valid, 1);
    s_if.aw_ready = 1'b1; s_if.w_ready = 1'b1;
    #1;
    chk("t6_m_aw_ready", m_aw_ready, 3'b010);
    step();
    m_aw_valid[1] = 1'b0; m_w_valid[1] = 1'b0;
    slave_idle();
    s_if.b_valid = 1'b1;
    #1;
    chk("t6_m_b_valid", m_b_valid, 3'b010);
    step();
    slave_idle();
    m_b_ready[1] = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
